// File: rtl/axi_imem_read_slave.sv
// -----------------------------------------------------------------------------
// axi_imem_read_slave
//
// AXI4 read-channel responder for instruction fetch. It accepts one AR request
// at a time, reads a synchronous single-port instruction SRAM one 32-bit word
// per beat and returns R beats with OKAY / SLVERR / DECERR responses.
//
// Beat timing: AR (or R) handshake on edge N -> mem_ce registered high after
// edge N+1 -> SRAM data valid after edge N+2 -> R beat valid after edge N+3.
//
// Optional feature (compile-time macro AXI_IMEM_WRAP_BURST_EN):
//   defined     : WRAP bursts wrap on a 4*(len+1)-byte boundary. ARLEN must be
//                 1, 3, 7 or 15, otherwise every beat returns SLVERR.
//   not defined : WRAP bursts are treated exactly like INCR, with no error.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        asynchronous active-low reset
//   ARID..     AR channel (ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID/ARREADY)
//   RID..      R channel  (RID, RDATA, RRESP, RLAST, RVALID/RREADY)
//   mem_ce     SRAM read enable (one cycle per issued read)
//   mem_addr   SRAM word address
//   mem_rdata  SRAM read data, valid the cycle after mem_ce
// -----------------------------------------------------------------------------
module axi_imem_read_slave #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH_W   = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [ID_W-1:0]    ARID,
    input  logic [ADDR_W-1:0]  ARADDR,
    input  logic [3:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    input  logic               ARVALID,
    output logic               ARREADY,

    output logic [ID_W-1:0]    RID,
    output logic [31:0]        RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic               RVALID,
    input  logic               RREADY,

    output logic               mem_ce,
    output logic [DEPTH_W-1:0] mem_addr,
    input  logic [31:0]        mem_rdata
);

    // -------------------------------------------------------------------------
    // Constants and types
    // -------------------------------------------------------------------------
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Size of the SRAM window in bytes, one bit wider than an address so the
    // limit itself is representable.
    localparam logic [ADDR_W:0] SPAN = {{ADDR_W{1'b0}}, 1'b1} << (DEPTH_W + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_WAIT,
        S_RESP
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic               rst_done_q;

    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         len_q;
    logic [1:0]         burst_q;
    logic [3:0]         beat_cnt_q;
    logic               err_q;        // whole burst answers SLVERR

    logic               rd_issued_q;  // current beat actually read the SRAM
    logic               dec_err_q;    // current beat fell outside the window
    logic               wait_phase_q; // second cycle of WAIT: SRAM data valid

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic               ar_fire;
    logic               r_fire;
    logic               ar_err;
    logic [ADDR_W:0]    offset;
    logic               in_range;
    logic               issue;
    logic [ADDR_W-1:0]  next_addr;

    assign ar_fire = ARVALID & ARREADY;
    assign r_fire  = RVALID & RREADY;

    // Extending by one bit makes an address below BASE_ADDR wrap to a value
    // with the top bit set, so a single compare covers both window bounds.
    assign offset   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign in_range = (offset < SPAN);
    assign issue    = in_range & ~err_q;

    // Request-level error: only 32-bit beats and non-reserved bursts are legal.
`ifdef AXI_IMEM_WRAP_BURST_EN
    logic wrap_len_ok;
    assign wrap_len_ok = (ARLEN == 4'd1) || (ARLEN == 4'd3) ||
                         (ARLEN == 4'd7) || (ARLEN == 4'd15);
    assign ar_err = (ARSIZE != 3'b010) || (ARBURST == BURST_RSVD) ||
                    ((ARBURST == BURST_WRAP) && !wrap_len_ok);
`else
    assign ar_err = (ARSIZE != 3'b010) || (ARBURST == BURST_RSVD);
`endif

`ifdef AXI_IMEM_WRAP_BURST_EN
    // Wrap boundary mask: 4*(len+1)-1, i.e. the byte span of the burst minus 1.
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_plus4;
    assign wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << 2) - ADDR_W'(1);
    assign addr_plus4 = addr_q + ADDR_W'(4);
`endif

    // Address of the following beat.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        next_addr = addr_q;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_INCR:  next_addr = addr_q + ADDR_W'(4);
`ifdef AXI_IMEM_WRAP_BURST_EN
            BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (addr_plus4 & wrap_mask);
`else
            BURST_WRAP:  next_addr = addr_q + ADDR_W'(4);
`endif
            default:     next_addr = addr_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ar_fire)      state_d = S_MEM;
            S_MEM:                    state_d = S_WAIT;
            // WAIT spans two cycles: SRAM access, then data capture.
            S_WAIT: if (wait_phase_q) state_d = S_RESP;
            S_RESP: if (r_fire)       state_d = RLAST ? S_IDLE : S_MEM;
            default:                  state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // The first edge after reset release only arms rst_done, so no request can
    // be accepted on that edge.
    always_comb begin
        ARREADY = (state_q == S_IDLE) && rst_done_q;
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register, outputs included, is cleared by the async
            // reset; this is what drops RVALID at once when a burst is aborted.
            rst_done_q   <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            burst_q      <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            rd_issued_q  <= 1'b0;
            dec_err_q    <= 1'b0;
            wait_phase_q <= 1'b0;
            mem_ce       <= 1'b0;
            mem_addr     <= '0;
            RID          <= '0;
            RDATA        <= '0;
            RRESP        <= RESP_OKAY;
            RLAST        <= 1'b0;
            RVALID       <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            mem_ce     <= 1'b0;   // single-cycle strobe

            case (state_q)
                S_IDLE: begin
                    if (ar_fire) begin
                        id_q       <= ARID;
                        addr_q     <= ARADDR;
                        len_q      <= ARLEN;
                        burst_q    <= ARBURST;
                        beat_cnt_q <= '0;
                        err_q      <= ar_err;
                    end
                end

                S_MEM: begin
                    rd_issued_q  <= issue;
                    dec_err_q    <= ~in_range;
                    wait_phase_q <= 1'b0;
                    if (issue) begin
                        mem_ce   <= 1'b1;
                        // Byte offset to word index; ARADDR[1:0] is dropped.
                        mem_addr <= offset[DEPTH_W+1:2];
                    end
                end

                S_WAIT: begin
                    if (!wait_phase_q) begin
                        wait_phase_q <= 1'b1;
                    end else begin
                        wait_phase_q <= 1'b0;
                        RDATA        <= rd_issued_q ? mem_rdata : 32'h0;
                        RRESP        <= err_q     ? RESP_SLVERR :
                                        dec_err_q ? RESP_DECERR : RESP_OKAY;
                        RLAST        <= (beat_cnt_q == len_q);
                        RID          <= id_q;
                        RVALID       <= 1'b1;
                    end
                end

                S_RESP: begin
                    // R payload is held untouched until the handshake.
                    if (r_fire) begin
                        RVALID <= 1'b0;
                        if (!RLAST) begin
                            beat_cnt_q <= beat_cnt_q + 4'd1;
                            addr_q     <= next_addr;
                        end
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_imem_read_slave.md
Name: axi_imem_read_slave

Overview:
- AXI4 read-channel responder that serves instruction-fetch reads from a synchronous single-port instruction SRAM.
- Sits on the slave side of the interconnect, opposite the CPU fetch master that drives the program counter out as ARADDR.
- Accepts one AR request at a time, reads the SRAM one word per beat and returns R beats with AXI-compliant response codes.

Parameters:
ID_W, 4, width of ARID/RID
ADDR_W, 32, width of ARADDR
DEPTH_W, 14, SRAM word-address width (2^DEPTH_W 32-bit words)
BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
ARID  input  ID_W  read address ID
ARADDR  input  ADDR_W  byte start address
ARLEN  input  4  beats minus one
ARSIZE  input  3  beat size
ARBURST  input  2  burst type
ARVALID  input  1  address valid
ARREADY  output  1  address ready
RID  output  ID_W  read ID
RDATA  output  32  read data
RRESP  output  2  response (00 OKAY, 10 SLVERR, 11 DECERR)
RLAST  output  1  final beat
RVALID  output  1  read data valid
RREADY  input  1  master ready
mem_ce  output  1  SRAM read enable
mem_addr  output  DEPTH_W  SRAM word address
mem_rdata  input  32  SRAM data, valid one cycle after mem_ce

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; RID/RDATA/RRESP/RLAST/RVALID/ARREADY/mem_ce/mem_addr = 0; the rst_done flag is cleared.
- First rising edge after reset release only sets rst_done; ARREADY stays 0 for that cycle. ARREADY = (state==IDLE) & rst_done.
- FSM states: IDLE, MEM, WAIT, RESP.
- IDLE: on ARVALID&ARREADY, latch ID, addr, len, size, burst, and clear beat_cnt to 0. Compute the error code: ARSIZE!=3'b010 or ARBURST==2'b11 -> SLVERR for every beat. Go to MEM.
- MEM: per-beat decode. The beat is in range if BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_W.
  - In range and no error: mem_ce=1 for one cycle, mem_addr = (addr-BASE_ADDR)[DEPTH_W+1:2].
  - Otherwise: mem_ce=0.
  - Go to WAIT.
- WAIT: register RDATA = mem_rdata if read issued, else 0. RRESP = SLVERR if an error was latched, else DECERR if out of range, else OKAY. RLAST = (beat_cnt==len). RID = latched ID. RVALID=1. Go to RESP.
- RESP: RVALID, RDATA, RID, RRESP and RLAST are held stable until RREADY=1.
  - On RVALID&RREADY with RLAST=1: RVALID=0 next cycle, go to IDLE.
  - On RVALID&RREADY without RLAST: beat_cnt+1, advance addr, go to MEM.
- Latency: AR handshake on edge N -> RVALID high after edge N+3. Subsequent beats arrive 3 cycles after each R handshake.
- Address advance:
  - FIXED (00): addr unchanged.
  - INCR (01): addr+4, wraps modulo 2^ADDR_W.
  - WRAP (10): see Optional Feature.
- ARADDR[1:0] is ignored for the SRAM index; RDATA is always the full aligned word.
- Only one outstanding transaction; ARREADY=0 outside IDLE.
- Reset mid-burst: the burst is abandoned immediately; RVALID drops asynchronously; no further beats are issued.

Optional Feature:
- Macro: AXI_IMEM_WRAP_BURST_EN.
- Defined: WRAP bursts are supported. ARLEN must be 1, 3, 7 or 15, otherwise SLVERR for all beats. mask = 4*(len+1)-1; next addr = (addr & ~mask) | ((addr+4) & mask).
- Not defined: ARBURST=10 is treated exactly as INCR, with no error.

Test Plan:
- Single read: SRAM word 5 = 32'hDEADBEEF; AR addr 0x14, len 0, INCR, ID 3 -> one beat RDATA DEADBEEF, RRESP 00, RLAST 1, RID 3, RVALID 3 cycles after the AR handshake.
- INCR len 3 at 0x100 with RREADY low for 4 cycles on beat 1 -> words 0x40..0x43 in order; beat-1 data held stable while stalled; RLAST only on beat 3; ARREADY returns to 1 after the last handshake.
- Out of range: DEPTH_W=14, addr 0x0001_0000 -> RRESP 11, RDATA 0, mem_ce never asserted. INCR len 1 at 0xFFFC -> beat0 OKAY, beat1 DECERR.
- FIXED len 2 at 0x8 -> three beats, all word 2, mem_addr=2 each beat. ARSIZE=3'b001 -> SLVERR on all beats.
- WRAP len 3 at 0x38 with macro defined -> addresses 0x38, 0x3C, 0x30, 0x34. Same stimulus without the macro -> 0x38, 0x3C, 0x40, 0x44.
- Reset pulse during beat 2 of a len-7 burst -> RVALID and ARREADY drop to 0 at once. ARREADY stays 0 for the first edge after release, then 1. A new single read then completes normally.
